// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per clock on a q/qn line.
// Define PISO_PARITY_EN to append an even-parity bit after the data word.
module piso_serial_tx #(
  parameter int   WIDTH      = 8,
  parameter int   LSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sd,
  output logic             sd_n,
  output logic             sd_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef PISO_PARITY_EN
    ST_PAR   = 2'd2,
`endif
    ST_SHIFT = 2'd1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sd;
  logic             r_sd_n;
  logic             r_sd_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    first_bit = (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // The shift register always presents the next bit to send at the outgoing end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    advance = (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

`ifdef PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    even_parity = ^w;
  endfunction
`endif

  // Frame sequencer; every output is registered and clr aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sd       <= IDLE_LEVEL;
      r_sd_n     <= ~IDLE_LEVEL;
      r_sd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
`ifdef PISO_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (din_valid && r_ready) begin
            r_state    <= ST_SHIFT;
            r_shift    <= advance(din);
            r_cnt      <= CW'(1);
            r_sd       <= first_bit(din);
            r_sd_n     <= ~first_bit(din);
            r_sd_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par      <= even_parity(din);
`endif
          end else begin
            r_sd       <= IDLE_LEVEL;
            r_sd_n     <= ~IDLE_LEVEL;
            r_sd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CW'(WIDTH)) begin
`ifdef PISO_PARITY_EN
            r_state <= ST_PAR;
            r_cnt   <= '0;
            r_sd    <= r_par;
            r_sd_n  <= ~r_par;
`else
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sd       <= IDLE_LEVEL;
            r_sd_n     <= ~IDLE_LEVEL;
            r_sd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_ready    <= 1'b1;
`endif
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_sd    <= first_bit(r_shift);
            r_sd_n  <= ~first_bit(r_shift);
            r_shift <= advance(r_shift);
          end
        end
`ifdef PISO_PARITY_EN
        ST_PAR: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_sd       <= IDLE_LEVEL;
          r_sd_n     <= ~IDLE_LEVEL;
          r_sd_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_ready    <= 1'b1;
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_shift    <= '0;
          r_cnt      <= '0;
          r_sd       <= IDLE_LEVEL;
          r_sd_n     <= ~IDLE_LEVEL;
          r_sd_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready = r_ready;
  assign sd        = r_sd;
  assign sd_n      = r_sd_n;
  assign sd_valid  = r_sd_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: an LSB-first and an MSB-first instance driven in lockstep,
// serial bits checked against a scoreboard queue, handshake/status checked per cycle.
module tb_piso_serial_tx;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_lsb;
    logic [7:0] seq_msb;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;

  logic din_ready_a, sd_a, sd_n_a, sd_valid_a, busy_a, done_a;
  logic din_ready_b, sd_b, sd_n_b, sd_valid_b, busy_b, done_b;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic exp_q_a[$];
  logic exp_q_b[$];
  vec_t vecs[10];

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) u_dut_a (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
    .sd(sd_a), .sd_n(sd_n_a), .sd_valid(sd_valid_a), .busy(busy_a), .done(done_a)
  );

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_dut_b (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
    .sd(sd_b), .sd_n(sd_n_b), .sd_valid(sd_valid_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected status nibble is {sd_valid, busy, done, din_ready}.
  task automatic chk_status(input string tag, input int k, input logic [3:0] e);
    chk($sformatf("%s_status_a_c%0d", tag, k), {28'd0, sd_valid_a, busy_a, done_a, din_ready_a}, {28'd0, e});
    chk($sformatf("%s_status_b_c%0d", tag, k), {28'd0, sd_valid_b, busy_b, done_b, din_ready_b}, {28'd0, e});
  endtask

  task automatic push_frame(input vec_t v, input int nbits);
    for (int i = 0; i < nbits && i < FL; i++) begin
      if (i < W) begin
        exp_q_a.push_back(v.seq_lsb[i]);
        exp_q_b.push_back(v.seq_msb[i]);
      end else begin
        exp_q_a.push_back(v.par);
        exp_q_b.push_back(v.par);
      end
    end
  endtask

  // Scoreboard monitor: pops one expected bit per valid serial cycle, idle level otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_sd_n_complement", {31'd0, sd_a ^ sd_n_a}, 32'd1);
      chk("b_sd_n_complement", {31'd0, sd_b ^ sd_n_b}, 32'd1);
      if (sd_valid_a) begin
        if (exp_q_a.size() == 0) chk("a_unexpected_bit", 32'd1, 32'd0);
        else chk("a_serial_bit", {31'd0, sd_a}, {31'd0, exp_q_a.pop_front()});
      end else begin
        chk("a_idle_level", {31'd0, sd_a}, 32'd1);
      end
      if (sd_valid_b) begin
        if (exp_q_b.size() == 0) chk("b_unexpected_bit", 32'd1, 32'd0);
        else chk("b_serial_bit", {31'd0, sd_b}, {31'd0, exp_q_b.pop_front()});
      end else begin
        chk("b_idle_level", {31'd0, sd_b}, 32'd1);
      end
    end
  end

  task automatic run_frame(input vec_t v);
    @(negedge clk);
    chk_status("frame_pre", 0, 4'b0001);
    din = v.din;
    din_valid = 1'b1;
    push_frame(v, FL);
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      if (k == 1) din_valid = 1'b0;
      if (k == 2) din = 8'hFF;
      chk_status("frame", k, {k <= FL, k <= FL, k == FL + 1, k == FL + 1});
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h81, 8'h81, 8'h81, 1'b0};
    vecs[2] = '{8'h12, 8'h12, 8'h48, 1'b0};
    vecs[3] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    vecs[4] = '{8'hC4, 8'hC4, 8'h23, 1'b1};
    vecs[5] = '{8'h01, 8'h01, 8'h80, 1'b1};
    vecs[6] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    vecs[7] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    vecs[8] = '{8'hF0, 8'hF0, 8'h0F, 1'b0};
    vecs[9] = '{8'h55, 8'h55, 8'hAA, 1'b0};

    // Reset: two cycles of clr, then idle values on both instances.
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk_status("reset", 0, 4'b0001);
    chk("reset_sd_a", {31'd0, sd_a}, 32'd1);
    chk("reset_sd_n_a", {31'd0, sd_n_a}, 32'd0);
    chk("reset_sd_b", {31'd0, sd_b}, 32'd1);
    chk("reset_sd_n_b", {31'd0, sd_n_b}, 32'd0);
    mon_en = 1'b1;

    // Single frames from the table, din scrambled after the accept edge.
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Back-to-back: valid held high across two words, one idle cycle between frames.
    @(negedge clk);
    din = vecs[7].din;
    din_valid = 1'b1;
    push_frame(vecs[7], FL);
    for (int k = 1; k <= 2 * FL + 2; k++) begin
      @(negedge clk);
      if (k == 1) din = vecs[8].din;
      if (k == FL + 1) push_frame(vecs[8], FL);
      if (k == FL + 2) din_valid = 1'b0;
      chk_status("b2b", k, {(k <= FL) || (k >= FL + 2 && k <= 2 * FL + 1),
                            (k <= FL) || (k >= FL + 2 && k <= 2 * FL + 1),
                            (k == FL + 1) || (k == 2 * FL + 2),
                            (k == FL + 1) || (k == 2 * FL + 2)});
      if (k == FL + 1) begin
        chk("b2b_gap_sd_a", {31'd0, sd_a}, 32'd1);
        chk("b2b_gap_sd_b", {31'd0, sd_b}, 32'd1);
      end
    end

    // Reset mid-frame: clr during cycle 4, idle from cycle 5, no done pulse.
    @(negedge clk);
    din = vecs[6].din;
    din_valid = 1'b1;
    push_frame(vecs[6], 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) din_valid = 1'b0;
      chk_status("abort", k, 4'b1100);
      if (k == 4) clr = 1'b1;
    end
    for (int k = 5; k <= FL + 3; k++) begin
      @(negedge clk);
      clr = 1'b0;
      chk_status("abort", k, 4'b0001);
    end
    run_frame(vecs[9]);

    @(negedge clk);
    chk("a_queue_drained", exp_q_a.size(), 32'd0);
    chk("b_queue_drained", exp_q_b.size(), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
